read_responder: RTL and testbench

READ_RESPONDER -- requirements
Module: read_responder

---
 rtl/pbl_fir_pkg.sv | 19 +
 rtl/read_responder.sv | 109 ++++++++++
 tb/tb_read_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbl_fir_pkg.sv
// Shared definitions for the FIR control-side read path.
// Holds the address and data widths, the read FSM state type, and a helper
// that classifies control-register addresses.
package pbl_fir_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int RAM_AW = 5;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} rd_state_t;

  // Only eight control registers exist. Any register-space address with
  // bits [4:3] nonzero has no register behind it.
  function automatic logic reg_unmapped(input logic [ADDR_W-1:0] a);
    return (a[4:3] != 2'b00);
  endfunction

endpackage

// File: rtl/read_responder.sv
// Read responder: services one CDC read at a time from either the
// coefficient RAM (addr bit5=0) or the control registers (addr bit5=1)
// and presents the result through a valid/ready response port.
//
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   CDC_A, CDC_rd    - read address and request (accepted only when idle)
//   rd_ready         - response consumer ready
//   RAM_dout         - RAM data, valid one cycle after rd_RAM
//   Rej_dout         - register data, combinational from nr_Rejestru_rd
//   rd_RAM           - RAM read strobe
//   address_RAM_rd   - RAM read address
//   nr_Rejestru_rd   - register read index
//   rd_data, rd_err  - response payload, qualified by rd_valid
//   rd_valid         - response valid
//   busy             - a read is in flight
//   rd_ovr           - a request arrived while busy and was dropped
module read_responder
  import pbl_fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] CDC_A,
  input  logic              CDC_rd,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] RAM_dout,
  input  logic [DATA_W-1:0] Rej_dout,
  output logic              rd_RAM,
  output logic [RAM_AW-1:0] address_RAM_rd,
  output logic [REG_AW-1:0] nr_Rejestru_rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              busy,
  output logic              rd_ovr
);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W-1:0] addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request address capture, only when a new read is accepted
  always_ff @(posedge clk) begin
    if (!rst_n)                       addr_q <= '0;
    else if (state == IDLE && CDC_rd) addr_q <= CDC_A;
  end

  // Response capture: registers are sampled during ISSUE because their
  // data is combinational; RAM data arrives one cycle later, in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (addr_q[5]) begin
            if (reg_unmapped(addr_q)) begin
              rd_data <= '0;
              rd_err  <= 1'b1;
            end else begin
              rd_data <= Rej_dout;
              rd_err  <= 1'b0;
            end
          end
        end
        WAIT: begin
          rd_data <= RAM_dout;
          rd_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Next-state and strobe logic
  always_comb begin
    state_nxt = state;
    rd_RAM    = 1'b0;
    case (state)
      IDLE:  if (CDC_rd) state_nxt = ISSUE;
      ISSUE: begin
        if (addr_q[5]) begin
          state_nxt = RESP;
        end else begin
          rd_RAM    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:  state_nxt = RESP;
      RESP:  if (rd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign address_RAM_rd = addr_q[RAM_AW-1:0];
  assign nr_Rejestru_rd = addr_q[REG_AW-1:0];
  assign rd_valid       = (state == RESP);
  assign busy           = (state != IDLE);
  // Requests are not queued; a request seen while busy is flagged and lost.
  assign rd_ovr         = CDC_rd && (state != IDLE);

endmodule

// File: tb/tb_read_responder.sv
module tb_read_responder;

  logic        clk;
  logic        rst_n;
  logic [5:0]  CDC_A;
  logic        CDC_rd;
  logic        rd_ready;
  logic [15:0] RAM_dout;
  logic [15:0] Rej_dout;
  logic        rd_RAM;
  logic [4:0]  address_RAM_rd;
  logic [2:0]  nr_Rejestru_rd;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        busy;
  logic        rd_ovr;

  int total;
  int bad;
  int hs_cnt;

  logic [15:0] mem  [0:31];
  logic [15:0] regs [0:7];

  read_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .CDC_A          (CDC_A),
    .CDC_rd         (CDC_rd),
    .rd_ready       (rd_ready),
    .RAM_dout       (RAM_dout),
    .Rej_dout       (Rej_dout),
    .rd_RAM         (rd_RAM),
    .address_RAM_rd (address_RAM_rd),
    .nr_Rejestru_rd (nr_Rejestru_rd),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_err         (rd_err),
    .busy           (busy),
    .rd_ovr         (rd_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (rd_RAM) RAM_dout <= mem[address_RAM_rd];
  end

  assign Rej_dout = regs[nr_Rejestru_rd];

  // Count completed handshakes
  always @(posedge clk) begin
    if (rst_n && rd_valid && rd_ready) hs_cnt = hs_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; CDC_rd = 1'b0; CDC_A = '0; rd_ready = 1'b1;
    tick(); tick();
    total++;
    if ({busy, rd_valid, rd_err, rd_RAM, rd_ovr} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, rd_valid, rd_err, rd_RAM, rd_ovr});
    end
    total++;
    if (rd_data !== 16'h0000 || address_RAM_rd !== 5'h00) begin
      bad++; $display("FAIL reset_data got data=%h addr=%h exp 0000/00", rd_data, address_RAM_rd);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ram_read();
    int hs0;
    hs0 = hs_cnt;
    CDC_A = 6'h05; CDC_rd = 1'b1; rd_ready = 1'b1;
    tick();                                  // T+1: ISSUE
    CDC_rd = 1'b0;
    total++;
    if (rd_RAM !== 1'b1 || address_RAM_rd !== 5'h05) begin
      bad++; $display("FAIL ram_issue got rd_RAM=%b addr=%h exp 1/05", rd_RAM, address_RAM_rd);
    end
    total++;
    if (busy !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL ram_issue_flags got busy=%b valid=%b exp 1/0", busy, rd_valid);
    end
    tick();                                  // T+2: WAIT
    total++;
    if (rd_RAM !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL ram_wait got rd_RAM=%b valid=%b exp 0/0", rd_RAM, rd_valid);
    end
    tick();                                  // T+3: RESP
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234 || rd_err !== 1'b0) begin
      bad++; $display("FAIL ram_resp got valid=%b data=%h err=%b exp 1/1234/0", rd_valid, rd_data, rd_err);
    end
    tick();
    total++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || hs_cnt - hs0 !== 1) begin
      bad++; $display("FAIL ram_done got busy=%b valid=%b hs=%0d exp 0/0/1", busy, rd_valid, hs_cnt - hs0);
    end
  endtask

  task automatic test_reg_read(input logic [5:0] a, input logic [15:0] exp_d,
                               input logic exp_e);
    logic saw_ram;
    saw_ram = 1'b0;
    CDC_A = a; CDC_rd = 1'b1; rd_ready = 1'b1;
    tick();                                  // T+1: ISSUE
    CDC_rd = 1'b0;
    saw_ram = saw_ram | rd_RAM;
    total++;
    if (rd_valid !== 1'b0 || nr_Rejestru_rd !== a[2:0]) begin
      bad++; $display("FAIL reg_issue a=%h got valid=%b idx=%0d exp 0/%0d", a, rd_valid, nr_Rejestru_rd, a[2:0]);
    end
    tick();                                  // T+2: RESP
    saw_ram = saw_ram | rd_RAM;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_err !== exp_e) begin
      bad++; $display("FAIL reg_resp a=%h got valid=%b data=%h err=%b exp 1/%h/%b", a, rd_valid, rd_data, rd_err, exp_d, exp_e);
    end
    total++;
    if (saw_ram !== 1'b0) begin
      bad++; $display("FAIL reg_no_ram a=%h got rd_RAM seen=%b exp 0", a, saw_ram);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reg_done a=%h got busy=%b exp 0", a, busy);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_cnt;
    CDC_A = 6'h0A; CDC_rd = 1'b1; rd_ready = 1'b0;
    tick(); CDC_rd = 1'b0;                   // ISSUE
    tick();                                  // WAIT
    for (int i = 0; i < 5; i++) begin
      tick();                                // RESP, held
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || rd_err !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h err=%b exp 1/beef/0", i, rd_valid, rd_data, rd_err);
      end
    end
    total++;
    if (hs_cnt - hs0 !== 0) begin
      bad++; $display("FAIL bp_no_hs got hs=%0d exp 0", hs_cnt - hs0);
    end
    rd_ready = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || hs_cnt - hs0 !== 1) begin
      bad++; $display("FAIL bp_release got busy=%b valid=%b hs=%0d exp 0/0/1", busy, rd_valid, hs_cnt - hs0);
    end
  endtask

  task automatic test_overrun();
    int hs0;
    hs0 = hs_cnt;
    CDC_A = 6'h00; CDC_rd = 1'b1; rd_ready = 1'b1;
    total++;
    #1;
    if (rd_ovr !== 1'b0) begin
      bad++; $display("FAIL ovr_idle got rd_ovr=%b exp 0", rd_ovr);
    end
    tick(); CDC_rd = 1'b0;                   // ISSUE
    tick();                                  // WAIT
    CDC_A = 6'h01; CDC_rd = 1'b1;
    #1;
    total++;
    if (rd_ovr !== 1'b1) begin
      bad++; $display("FAIL ovr_pulse got rd_ovr=%b exp 1", rd_ovr);
    end
    tick();                                  // RESP
    CDC_rd = 1'b0;
    #1;
    total++;
    if (rd_ovr !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 16'h0F0F || address_RAM_rd !== 5'h00) begin
      bad++; $display("FAIL ovr_resp got ovr=%b valid=%b data=%h addr=%h exp 0/1/0f0f/00", rd_ovr, rd_valid, rd_data, address_RAM_rd);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL ovr_after cyc=%0d got valid=%b busy=%b exp 0/0", i, rd_valid, busy);
      end
    end
    total++;
    if (hs_cnt - hs0 !== 1) begin
      bad++; $display("FAIL ovr_hs_count got hs=%0d exp 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_mid_read();
    CDC_A = 6'h05; CDC_rd = 1'b1; rd_ready = 1'b1;
    tick(); CDC_rd = 1'b0;                   // ISSUE
    tick();                                  // WAIT
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, rd_valid, rd_err, rd_RAM, rd_ovr} !== 5'b0 || rd_data !== 16'h0 || address_RAM_rd !== 5'h0) begin
      bad++; $display("FAIL midrst_outs got ctrl=%b data=%h addr=%h exp 00000/0000/00", {busy, rd_valid, rd_err, rd_RAM, rd_ovr}, rd_data, address_RAM_rd);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL midrst_quiet cyc=%0d got valid=%b busy=%b exp 0/0", i, rd_valid, busy);
      end
    end
  endtask

  task automatic test_accept_after_reset();
    rst_n = 1'b0; CDC_rd = 1'b0; rd_ready = 1'b1;
    tick();
    rst_n = 1'b1; CDC_A = 6'h21; CDC_rd = 1'b1;
    tick();                                  // ISSUE
    CDC_rd = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL post_rst_accept got busy=%b exp 1", busy);
    end
    tick();                                  // RESP
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A || rd_err !== 1'b0) begin
      bad++; $display("FAIL post_rst_resp got valid=%b data=%h err=%b exp 1/5a5a/0", rd_valid, rd_data, rd_err);
    end
    tick();
  endtask

  initial begin
    total = 0; bad = 0; hs_cnt = 0;
    RAM_dout = 16'h0000;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++)  regs[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'h0F0F;
    mem[1]  = 16'h1111;
    mem[5]  = 16'h1234;
    mem[10] = 16'hBEEF;
    regs[1] = 16'h5A5A;
    regs[2] = 16'hA5A5;
    regs[7] = 16'hC3C3;

    test_reset();
    test_ram_read();
    test_reg_read(6'h22, 16'hA5A5, 1'b0);
    test_reg_read(6'h27, 16'hC3C3, 1'b0);
    test_reg_read(6'h3F, 16'h0000, 1'b1);
    test_reg_read(6'h2B, 16'h0000, 1'b1);
    test_backpressure();
    test_overrun();
    test_reset_mid_read();
    test_accept_after_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
